// File: rtl/biriscv_div_sched.sv
// Scheduler that shares one iterative divider between two issue pipes.
// Define BIRISCV_DIV_SCHED_RR_EN for round-robin contests; otherwise port 0 has fixed priority.
module biriscv_div_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req0_valid_i,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    input  logic        req1_valid_i,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    output logic        grant0_o,
    output logic        grant1_o,

    input  logic        squash_i,
    input  logic        stall_i,

    output logic        div_start_o,
    output logic [31:0] div_opcode_o,
    output logic [31:0] div_ra_o,
    output logic [31:0] div_rb_o,
    input  logic        div_complete_i,
    input  logic [31:0] div_result_i,

    output logic        res_valid_o,
    output logic        res_port_o,
    output logic [4:0]  res_rd_o,
    output logic [31:0] res_value_o,
    output logic        busy_o,
    output logic        err_o
);

    // state | meaning
    // IDLE  | no operation in flight; grants may be issued
    // BUSY  | divider running for the owning pipe
    // DRAIN | operation squashed; waiting for the divider to finish
    // HOLD  | result presented, writeback stalled
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HOLD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       owner;
    logic       can_grant;
    logic       pick1;

`ifdef BIRISCV_DIV_SCHED_RR_EN
    logic       rr_ptr;   // 1: port 1 wins the next two-way contest

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= 1'b0;
        end else if (grant0_o || grant1_o) begin
            rr_ptr <= grant0_o;
        end
    end

    assign pick1 = req1_valid_i && (!req0_valid_i || rr_ptr);
`else
    assign pick1 = req1_valid_i && !req0_valid_i;
`endif

    // Reset is folded in so the grants read 0 while rst_ni is held low.
    assign can_grant = rst_ni && (state == IDLE) && !squash_i;
    assign grant0_o  = can_grant && req0_valid_i && !pick1;
    assign grant1_o  = can_grant && pick1;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            owner        <= 1'b0;
            div_start_o  <= 1'b0;
            div_opcode_o <= 32'd0;
            div_ra_o     <= 32'd0;
            div_rb_o     <= 32'd0;
            res_valid_o  <= 1'b0;
            res_port_o   <= 1'b0;
            res_rd_o     <= 5'd0;
            res_value_o  <= 32'd0;
            err_o        <= 1'b0;
        end else begin
            div_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    res_valid_o <= 1'b0;
                    if (grant0_o || grant1_o) begin
                        state        <= BUSY;
                        div_start_o  <= 1'b1;
                        cnt          <= 8'd0;
                        owner        <= grant1_o;
                        div_opcode_o <= grant1_o ? req1_opcode_i : req0_opcode_i;
                        div_ra_o     <= grant1_o ? req1_ra_i     : req0_ra_i;
                        div_rb_o     <= grant1_o ? req1_rb_i     : req0_rb_i;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (div_complete_i) begin
                        if (squash_i) begin
                            state <= IDLE;
                        end else begin
                            res_valid_o <= 1'b1;
                            res_value_o <= div_result_i;
                            res_rd_o    <= div_opcode_o[11:7];
                            res_port_o  <= owner;
                            state       <= stall_i ? HOLD : IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end else if (squash_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The divider cannot abort, so wait for its completion and drop it.
                    cnt <= cnt + 8'd1;
                    if (div_complete_i) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (squash_i) begin
                        res_valid_o <= 1'b0;
                        state       <= IDLE;
                    end else if (!stall_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biriscv_div_sched.sv
// Directed and randomized bench for biriscv_div_sched with a latency-programmable divider model.
module tb_biriscv_div_sched;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_opcode, req0_ra, req0_rb;
    logic [31:0] req1_opcode, req1_ra, req1_rb;
    logic        grant0, grant1;
    logic        squash, stall;
    logic        div_start;
    logic [31:0] div_opcode, div_ra, div_rb;
    logic        div_complete;
    logic [31:0] div_result;
    logic        res_valid, res_port;
    logic [4:0]  res_rd;
    logic [31:0] res_value;
    logic        busy, err;

    int n_cmp = 0;
    int n_bad = 0;
    int div_lat = 0;
    int div_left;
    bit exp_err = 1'b0;
    int last_grant = 1;

    always #5 clk = ~clk;

    biriscv_div_sched #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_opcode_i(req0_opcode), .req0_ra_i(req0_ra), .req0_rb_i(req0_rb),
        .req1_valid_i(req1_valid), .req1_opcode_i(req1_opcode), .req1_ra_i(req1_ra), .req1_rb_i(req1_rb),
        .grant0_o(grant0), .grant1_o(grant1),
        .squash_i(squash), .stall_i(stall),
        .div_start_o(div_start), .div_opcode_o(div_opcode), .div_ra_o(div_ra), .div_rb_o(div_rb),
        .div_complete_i(div_complete), .div_result_i(div_result),
        .res_valid_o(res_valid), .res_port_o(res_port), .res_rd_o(res_rd), .res_value_o(res_value),
        .busy_o(busy), .err_o(err)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    // Divider model: completion pulse div_lat cycles after the start cycle; div_lat 0 never completes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_left     <= 0;
            div_complete <= 1'b0;
            div_result   <= 32'd0;
        end else if (div_start) begin
            div_left     <= div_lat;
            div_complete <= (div_lat == 1);
            div_result   <= ref_div(div_ra, div_rb);
        end else begin
            if (div_left != 0) div_left <= div_left - 1;
            div_complete <= (div_left == 2);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h required 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] opc,
                           input logic [31:0] ra, input logic [31:0] rb);
        if (port == 0) begin
            req0_valid = v; req0_opcode = opc; req0_ra = ra; req0_rb = rb;
        end else begin
            req1_valid = v; req1_opcode = opc; req1_ra = ra; req1_rb = rb;
        end
    endtask

    task automatic chk_all_zero();
        chk1("rst_grant0", grant0, 1'b0);
        chk1("rst_grant1", grant1, 1'b0);
        chk1("rst_div_start", div_start, 1'b0);
        chk32("rst_div_opcode", div_opcode, 32'd0);
        chk32("rst_div_ra", div_ra, 32'd0);
        chk32("rst_div_rb", div_rb, 32'd0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_res_port", res_port, 1'b0);
        chk32("rst_res_rd", {27'd0, res_rd}, 32'd0);
        chk32("rst_res_value", res_value, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
    endtask

    // One operation from an IDLE cycle (cycle 0 = grant, 1 = start, 1+lat = completion).
    // nstall: stall cycles beginning at the completion cycle; squash_at: cycle of a 1-cycle squash (-1 none).
    // hold_other: the other pipe requests from cycle 1 on and must only see a grant once IDLE returns.
    task automatic run_op(input int port, input logic [31:0] ra, input logic [31:0] rb,
                          input logic [4:0] rd, input int lat, input int nstall,
                          input int squash_at, input bit hold_other);
        logic [31:0] opc, expv;
        int  idle_c, vis_last;
        bit  has_res, tmo, vis;
        opc       = $urandom;
        opc[11:7] = rd;
        expv      = ref_div(ra, rb);
        tmo       = (lat == 0);
        div_lat   = lat;
        has_res   = 1'b0;
        vis_last  = -1;
        if (tmo) begin
            idle_c = 1 + TMO;
        end else if (squash_at >= 1 && squash_at <= 1 + lat) begin
            idle_c = 2 + lat;
        end else if (squash_at >= 2 + lat && squash_at <= 1 + lat + nstall) begin
            idle_c = squash_at + 1; has_res = 1'b1; vis_last = squash_at;
        end else begin
            idle_c = 2 + lat + nstall; has_res = 1'b1; vis_last = idle_c;
        end

        set_req(port, 1'b1, opc, ra, rb);
        #1;
        chk1("grant_own", (port == 1) ? grant1 : grant0, 1'b1);
        chk1("grant_other", (port == 1) ? grant0 : grant1, 1'b0);
        last_grant = port;
        step();
        set_req(port, 1'b0, opc, ra, rb);

        for (int c = 1; c <= idle_c; c++) begin
            stall  = !tmo && (c >= 1 + lat) && (c < 1 + lat + nstall);
            squash = (c == squash_at);
            if (port == 1) req0_valid = hold_other; else req1_valid = hold_other;
            #1;
            vis = has_res && (c >= 2 + lat) && (c <= vis_last);
            chk1("div_start", div_start, c == 1);
            if (c == 1) begin
                chk32("div_opcode", div_opcode, opc);
                chk32("div_ra", div_ra, ra);
                chk32("div_rb", div_rb, rb);
            end
            chk1("busy", busy, c < idle_c);
            chk1("res_valid", res_valid, vis);
            if (vis) begin
                chk32("res_value", res_value, expv);
                chk32("res_rd", {27'd0, res_rd}, {27'd0, rd});
                chk1("res_port", res_port, port == 1);
            end
            chk1("err", err, exp_err || (tmo && c >= idle_c));
            chk1("grant_own_idle", (port == 1) ? grant1 : grant0, 1'b0);
            if (hold_other) chk1("grant_held_req", (port == 1) ? grant0 : grant1, c == idle_c);
            if (c == idle_c) begin
                req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0; squash = 1'b0;
            end
            step();
        end
        if (tmo) exp_err = 1'b1;
        #1;
        chk1("after_res_valid", res_valid, 1'b0);
        chk1("after_busy", busy, 1'b0);
        chk1("after_err", err, exp_err);
        step();
    endtask

    // Both pipes request continuously; a new grant is expected every lat+2 cycles.
    task automatic run_contest(input int lat, input int rounds);
        logic [31:0] a0, b0, a1, b1, o0, o1;
        int per, w, prev_w;
        a0 = $urandom; b0 = $urandom_range(1, 1000);
        a1 = $urandom; b1 = $urandom_range(1, 1000);
        o0 = $urandom; o0[11:7] = 5'd3;
        o1 = $urandom; o1[11:7] = 5'd9;
        per = lat + 2; div_lat = lat; prev_w = 0; w = 0;
        set_req(0, 1'b1, o0, a0, b0);
        set_req(1, 1'b1, o1, a1, b1);
        for (int c = 0; c <= rounds * per; c++) begin
            if (c == rounds * per) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (c % per == 0 && c > 0) begin
                chk1("contest_res_valid", res_valid, 1'b1);
                chk1("contest_res_port", res_port, prev_w == 1);
                chk32("contest_res_value", res_value, (prev_w == 1) ? ref_div(a1, b1) : ref_div(a0, b0));
                chk32("contest_res_rd", {27'd0, res_rd}, (prev_w == 1) ? 32'd9 : 32'd3);
            end
            if (c % per == 0 && c < rounds * per) begin
`ifdef BIRISCV_DIV_SCHED_RR_EN
                w = 1 - last_grant;
`else
                w = 0;
`endif
                chk1("contest_grant0", grant0, w == 0);
                chk1("contest_grant1", grant1, w == 1);
                last_grant = w;
                prev_w = w;
            end else begin
                chk1("contest_grant0_off", grant0, 1'b0);
                chk1("contest_grant1_off", grant1, 1'b0);
            end
            step();
        end
        #1;
        chk1("contest_end_valid", res_valid, 1'b0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, l, n, s, mode;
        logic [31:0] rb, opc;

        rst_n = 1'b0; squash = 1'b0; stall = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 32'd0);
        #3;
        chk_all_zero();
        step(); step();
        rst_n = 1'b1;
        step();

        run_contest(3, 4);
        run_op(0, 32'd100, 32'd7, 5'd5, 34, 0, -1, 1'b0);
        run_op(1, $urandom, 32'd3, 5'd17, 1, 0, -1, 1'b0);
        run_op(0, $urandom, 32'd11, 5'd31, TMO - 1, 0, -1, 1'b0);
        run_op(0, $urandom, 32'd5, 5'd8, 20, 0, 11, 1'b1);
        run_op(1, $urandom, 32'd9, 5'd2, 8, 0, 9, 1'b0);
        run_op(0, $urandom, 32'd13, 5'd4, 5, 3, 8, 1'b0);
        run_op(1, 32'hDEAD_BEEF, 32'd1, 5'd12, 10, 3, -1, 1'b0);

        // A grant and a squash in the same cycle cancel each other.
        squash = 1'b1;
        set_req(0, 1'b1, 32'h0000_0380, 32'd50, 32'd5);
        #1;
        chk1("cancel_grant0", grant0, 1'b0);
        chk1("cancel_grant1", grant1, 1'b0);
        step();
        squash = 1'b0;
        set_req(0, 1'b0, 32'h0000_0380, 32'd50, 32'd5);
        #1;
        chk1("cancel_no_start", div_start, 1'b0);
        chk1("cancel_busy", busy, 1'b0);
        step();

        for (int i = 0; i < 10; i++) begin
            p = $urandom_range(0, 1);
            l = $urandom_range(1, 38);
            n = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            if (mode == 2) s = $urandom_range(1, 1 + l);
            else if (mode == 3 && n > 0) s = $urandom_range(2 + l, 1 + l + n);
            else s = -1;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 70000));
            run_op(p, $urandom, rb, 5'($urandom), l, n, s, 1'($urandom_range(0, 1)));
        end

        run_op(1, $urandom, 32'd7, 5'd6, 0, 0, -1, 1'b0);
        run_op(0, $urandom, 32'd3, 5'd7, 6, 1, -1, 1'b0);

        // Reset in the middle of BUSY.
        opc = 32'h0000_0A80;
        div_lat = 30;
        set_req(0, 1'b1, opc, 32'd999, 32'd3);
        #1;
        chk1("midrst_grant", grant0, 1'b1);
        last_grant = 0;
        step();
        set_req(0, 1'b0, opc, 32'd999, 32'd3);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        exp_err = 1'b0;
        chk_all_zero();
        step();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        last_grant = 1;
        step();
        run_contest(2, 2);
        run_op(1, $urandom, 32'd21, 5'd19, 4, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
